// File: rtl/sram_controller_pkg.sv
// Shared state encoding and default timing for the external SRAM controller.
package sram_controller_pkg;

  localparam int DEFAULT_WAIT_CYCLES = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_RECOVER = 2'd2
  } state_t;

endpackage

// File: rtl/sram_controller.sv
// Sequences single-word read/write accesses onto an asynchronous 256Kx16 SRAM.
// Every pin is driven from a flop so strobes never glitch.
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int ADDR_WIDTH  = 18,
  parameter int DATA_WIDTH  = 16,
  parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
  input  logic                  CLK_100MHz,
  input  logic                  RESET,
  input  logic                  REQ,
  input  logic                  WE,
  input  logic [ADDR_WIDTH-1:0] ADDR,
  input  logic [DATA_WIDTH-1:0] DATA_W,
  output logic [DATA_WIDTH-1:0] DATA_R,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [ADDR_WIDTH-1:0] SRAM_ADDR,
  output logic [DATA_WIDTH-1:0] SRAM_DATA_OUT,
  input  logic [DATA_WIDTH-1:0] SRAM_DATA_IN,
  output logic                  SRAM_DATA_OE,
  output logic                  SRAM_CSX,
  output logic                  SRAM_WEX,
  output logic                  SRAM_OEX
);

  localparam int             CW   = $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0]  LAST = CW'(WAIT_CYCLES - 1);

  if (WAIT_CYCLES < 1) begin : g_bad_wait
    $error("sram_controller: WAIT_CYCLES must be at least 1");
  end

  state_t        state;
  logic          we_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge CLK_100MHz) begin
    if (RESET) begin
      state         <= ST_IDLE;
      we_q          <= 1'b0;
      cnt           <= '0;
      DATA_R        <= '0;
      BUSY          <= 1'b0;
      DONE          <= 1'b0;
      SRAM_ADDR     <= '0;
      SRAM_DATA_OUT <= '0;
      SRAM_DATA_OE  <= 1'b0;
      SRAM_CSX      <= 1'b1;
      SRAM_WEX      <= 1'b1;
      SRAM_OEX      <= 1'b1;
    end else begin
      DONE <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (REQ) begin
            // Strobes are set on the accept edge so they are live in the first ACTIVE cycle.
            state         <= ST_ACTIVE;
            we_q          <= WE;
            cnt           <= '0;
            SRAM_ADDR     <= ADDR;
            SRAM_DATA_OUT <= DATA_W;
            BUSY          <= 1'b1;
            SRAM_CSX      <= 1'b0;
            SRAM_WEX      <= ~WE;
            SRAM_OEX      <= WE;
            SRAM_DATA_OE  <= WE;
          end
        end
        ST_ACTIVE: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state    <= ST_RECOVER;
            DONE     <= 1'b1;
            SRAM_CSX <= 1'b1;
            SRAM_WEX <= 1'b1;
            SRAM_OEX <= 1'b1;
            if (!we_q) DATA_R <= SRAM_DATA_IN;
          end
        end
        ST_RECOVER: begin
          // Write data was held one extra cycle past WEX rise; release the bus now.
          state        <= ST_IDLE;
          BUSY         <= 1'b0;
          SRAM_DATA_OE <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller: default timing instance plus a WAIT_CYCLES=1 instance.
module tb_sram_controller;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req0, we0, busy0, done0, oe0, csx0, wex0, oex0;
  logic [17:0] addr0, sa0;
  logic [15:0] dw0, dr0, sdo0, sdi0;
  logic        req1, we1, busy1, done1, oe1, csx1, wex1, oex1;
  logic [17:0] addr1, sa1;
  logic [15:0] dw1, dr1, sdo1, sdi1;

  sram_controller #(.ADDR_WIDTH(18), .DATA_WIDTH(16), .WAIT_CYCLES(2)) dut0 (
    .CLK_100MHz(clk), .RESET(rst), .REQ(req0), .WE(we0), .ADDR(addr0), .DATA_W(dw0),
    .DATA_R(dr0), .BUSY(busy0), .DONE(done0), .SRAM_ADDR(sa0), .SRAM_DATA_OUT(sdo0),
    .SRAM_DATA_IN(sdi0), .SRAM_DATA_OE(oe0), .SRAM_CSX(csx0), .SRAM_WEX(wex0), .SRAM_OEX(oex0));

  sram_controller #(.ADDR_WIDTH(18), .DATA_WIDTH(16), .WAIT_CYCLES(1)) dut1 (
    .CLK_100MHz(clk), .RESET(rst), .REQ(req1), .WE(we1), .ADDR(addr1), .DATA_W(dw1),
    .DATA_R(dr1), .BUSY(busy1), .DONE(done1), .SRAM_ADDR(sa1), .SRAM_DATA_OUT(sdo1),
    .SRAM_DATA_IN(sdi1), .SRAM_DATA_OE(oe1), .SRAM_CSX(csx1), .SRAM_WEX(wex1), .SRAM_OEX(oex1));

  // One-word SRAM model for dut0: remembers the last written word.
  logic [17:0] mw_addr = '0;
  logic [15:0] mw_data = '0;
  always @(posedge clk) if (!csx0 && !wex0) begin mw_addr <= sa0; mw_data <= sdo0; end
  always_comb begin
    sdi0 = 16'h0;
    if (!csx0 && !oex0) sdi0 = (sa0 == mw_addr) ? mw_data : 16'hDEAD;
  end
  // Fixed-content model for dut1 covering the two address extremes.
  always_comb begin
    sdi1 = 16'h0;
    if (!csx1 && !oex1) sdi1 = (sa1 == 18'h0) ? 16'h1234 : (sa1 == 18'h3FFFF) ? 16'hA5C3 : 16'hDEAD;
  end

  int total = 0, passed = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else passed++;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [3:0]  e_csx, e_wex, e_oex, e_oe, e_done, e_busy;
  logic [9:0]  acc;
  logic        prev_busy, done_seen;
  int          viol;
  logic [17:0] rd_addr [2];
  logic [15:0] rd_data [2];

  initial begin
    rst = 1'b1; req0 = 1'b1; we0 = 1'b1; addr0 = 18'h5; dw0 = 16'h7;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; dw1 = '0;
    // REQ during reset must not start anything
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_csx", csx0, 1'b1);
      chk("rst_busy", busy0, 1'b0);
    end
    rst = 1'b0; req0 = 1'b0;
    step();
    chk("rv_busy", busy0, 1'b0);  chk("rv_done", done0, 1'b0);
    chk("rv_data_r", dr0, 16'h0); chk("rv_addr", sa0, 18'h0);
    chk("rv_dout", sdo0, 16'h0);  chk("rv_oe", oe0, 1'b0);
    chk("rv_csx", csx0, 1'b1);    chk("rv_wex", wex0, 1'b1);
    chk("rv_oex", oex0, 1'b1);    chk("rv1_busy", busy1, 1'b0);

    // write 0xBEEF to 0x3ABCD; bit k = cycle n+1+k
    e_csx = 4'b1100; e_wex = 4'b1100; e_oex = 4'b1111; e_oe = 4'b0111; e_done = 4'b0100; e_busy = 4'b0111;
    req0 = 1'b1; we0 = 1'b1; addr0 = 18'h3ABCD; dw0 = 16'hBEEF;
    step();
    req0 = 1'b0; addr0 = '0; dw0 = '0;
    for (int k = 0; k < 4; k++) begin
      chk("wr_csx", csx0, e_csx[k]);  chk("wr_wex", wex0, e_wex[k]);
      chk("wr_oex", oex0, e_oex[k]);  chk("wr_oe", oe0, e_oe[k]);
      chk("wr_done", done0, e_done[k]); chk("wr_busy", busy0, e_busy[k]);
      chk("wr_addr", sa0, 18'h3ABCD); chk("wr_dout", sdo0, 16'hBEEF);
      step();
    end

    // read it back
    e_wex = 4'b1111; e_oex = 4'b1100; e_oe = 4'b0000;
    req0 = 1'b1; we0 = 1'b0; addr0 = 18'h3ABCD;
    step();
    req0 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("rd_csx", csx0, e_csx[k]);  chk("rd_wex", wex0, e_wex[k]);
      chk("rd_oex", oex0, e_oex[k]);  chk("rd_oe", oe0, e_oe[k]);
      chk("rd_done", done0, e_done[k]); chk("rd_busy", busy0, e_busy[k]);
      if (k >= 2) chk("rd_data_r", dr0, 16'hBEEF);
      step();
    end

    // REQ held for 10 cycles, WE flipping every 4 cycles
    acc = '0; viol = 0; prev_busy = busy0;
    for (int i = 0; i < 10; i++) begin
      req0 = 1'b1; we0 = ((i / 4) % 2) == 0; addr0 = 18'h100 + 18'(i); dw0 = 16'(i);
      step();
      if (busy0 && !prev_busy) acc[i] = 1'b1;
      if (oe0 && !oex0) viol++;
      prev_busy = busy0;
    end
    req0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (oe0 && !oex0) viol++;
    end
    chk("b2b_accepts", acc, 10'h111);
    chk("turnaround", viol, 0);
    chk("b2b_idle", busy0, 1'b0);

    // reset during the first ACTIVE cycle of a write
    req0 = 1'b1; we0 = 1'b1; addr0 = 18'h2; dw0 = 16'h55AA;
    step();
    chk("rm_active_wex", wex0, 1'b0);
    rst = 1'b1; req0 = 1'b0;
    step();
    chk("rm_wex", wex0, 1'b1); chk("rm_csx", csx0, 1'b1);
    chk("rm_oe", oe0, 1'b0);   chk("rm_busy", busy0, 1'b0);
    chk("rm_done", done0, 1'b0); chk("rm_data_r", dr0, 16'h0);
    rst = 1'b0; done_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      done_seen |= done0;
    end
    chk("rm_no_done", done_seen, 1'b0);

    // WAIT_CYCLES=1: reads at both address extremes, 3 cycles each
    rd_addr[0] = 18'h0;     rd_data[0] = 16'h1234;
    rd_addr[1] = 18'h3FFFF; rd_data[1] = 16'hA5C3;
    for (int j = 0; j < 2; j++) begin
      req1 = 1'b1; addr1 = rd_addr[j];
      step();
      req1 = 1'b0;
      chk("w1_oex", oex1, 1'b0);   chk("w1_csx", csx1, 1'b0);
      chk("w1_addr", sa1, rd_addr[j]); chk("w1_busy", busy1, 1'b1);
      chk("w1_done_early", done1, 1'b0);
      step();
      chk("w1_done", done1, 1'b1); chk("w1_data_r", dr1, rd_data[j]);
      chk("w1_oex_off", oex1, 1'b1);
      step();
      chk("w1_idle", busy1, 1'b0); chk("w1_done_off", done1, 1'b0);
      chk("w1_hold", dr1, rd_data[j]);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
